op_buffer_drain: RTL

Output buffer and drain engine on the result side of the systolic array. Captures 32-bit results written by the accumulator (data, 4-bit address, write-enable) into a 16-entry register file with per-entry valid flags. On command, streams a contiguous range of entries out over a valid/ready read port toward the host/DMA, stalling on entries not yet written and freeing each entry as it is consumed.

---
 rtl/op_buffer_drain_if.sv | 29 ++
 rtl/op_buffer_drain.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/op_buffer_drain_if.sv
// Bus bundle for op_buffer_drain: accumulator write port, drain command, streaming read port, status.
interface op_buffer_drain_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_addr;
  logic              wr_en;
  logic              drain_start;
  logic [3:0]        drain_base;
  logic [4:0]        drain_count;
  logic              buf_clear;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        rd_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              busy;
  logic              overwrite_err;

  modport master (
    output wr_data, wr_addr, wr_en, drain_start, drain_base, drain_count, buf_clear, rd_ready,
    input  rd_data, rd_addr, rd_valid, rd_last, busy, overwrite_err
  );

  modport slave (
    input  wr_data, wr_addr, wr_en, drain_start, drain_base, drain_count, buf_clear, rd_ready,
    output rd_data, rd_addr, rd_valid, rd_last, busy, overwrite_err
  );
endinterface

// File: rtl/op_buffer_drain.sv
// Result-side output buffer: 16-entry register file with valid flags, drained in order over valid/ready.
module op_buffer_drain (
  input  logic             i_clk,
  input  logic             i_rst_n,
  op_buffer_drain_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned CW     = 5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_ptr, w_ptr_nxt;
  logic [CW-1:0]     r_rem, w_rem_nxt;
  logic [CW-1:0]     w_eff_cnt;
  logic              w_load;
  logic              w_hs;
  logic              w_wr_hit_ptr;
  logic              w_clr_ptr;
  logic              w_ovw;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [DATA_W-1:0] r_rd_data;
  logic [AW-1:0]     r_rd_addr;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_busy;
  logic              r_ovw_err;

  // Drain length: zero stays a no-op, anything beyond the buffer depth saturates.
  always_comb begin
    w_eff_cnt = bus.drain_count;
    if (bus.drain_count > CW'(DEPTH)) begin
      w_eff_cnt = CW'(DEPTH);
    end
  end

  // A write landing on the entry being consumed keeps it valid and is not an overwrite.
  always_comb begin
    w_hs         = (r_state == S_SEND) && bus.rd_ready;
    w_wr_hit_ptr = bus.wr_en && (bus.wr_addr == r_ptr);
    w_clr_ptr    = w_hs && !w_wr_hit_ptr;
    w_ovw        = bus.wr_en && r_vld[bus.wr_addr] && !(w_hs && w_wr_hit_ptr);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.drain_start && (w_eff_cnt != '0)) begin
          w_state_nxt = S_WAIT;
          w_ptr_nxt   = bus.drain_base;
          w_rem_nxt   = w_eff_cnt;
        end
      end
      S_WAIT: begin
        if (r_vld[r_ptr]) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.rd_ready) begin
          w_ptr_nxt   = r_ptr + AW'(1);
          w_rem_nxt   = r_rem - CW'(1);
          w_state_nxt = (r_rem == CW'(1)) ? S_IDLE : S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.buf_clear) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Entry storage has no reset: only the valid flags define what is live.
  always_ff @(posedge i_clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else if (bus.buf_clear) begin
      r_vld <= '0;
    end else begin
      if (w_clr_ptr) begin
        r_vld[r_ptr] <= 1'b0;
      end
      if (bus.wr_en) begin
        r_vld[bus.wr_addr] <= 1'b1;
      end
    end
  end

  // Read-port registers: the word is captured on entry to SEND and held until the handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_ovw_err  <= 1'b0;
    end else begin
      r_rd_valid <= (w_state_nxt == S_SEND);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_rd_data <= r_mem[r_ptr];
        r_rd_addr <= r_ptr;
        r_rd_last <= (r_rem == CW'(1));
      end else if (w_state_nxt != S_SEND) begin
        r_rd_last <= 1'b0;
      end
      if (bus.buf_clear) begin
        r_ovw_err <= 1'b0;
      end else if (w_ovw) begin
        r_ovw_err <= 1'b1;
      end
    end
  end

  assign bus.rd_data       = r_rd_data;
  assign bus.rd_addr       = r_rd_addr;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_last       = r_rd_last;
  assign bus.busy          = r_busy;
  assign bus.overwrite_err = r_ovw_err;
endmodule
